if_fetch: RTL and testbench

Instruction-fetch stage of the AdamRiscv five-stage pipeline, directly upstream of the decode stage that feeds the control decoder. It owns the PC, issues requests to instruction memory over a hold-until-ack handshake, and absorbs memory responses into a one-entry skid buffer. It drives the IF/ID pipeline register that delivers `{pc, inst, valid}` to decode. It also handles decode stalls and branch/jump redirects from EX, including redirects that arrive while a fetch is still in flight.

---
 rtl/if_fetch.sv | 134 +++++++++++++
 tb/tb_if_fetch.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch
// Brief    : Instruction-fetch stage with hold-until-ack imem handshake,
//            one-entry skid buffer, and redirect draining of stale responses.
// Revision : 1.0
// ============================================================================
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        id_stall,
    output logic        if_id_valid,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_inst
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] drain_addr_q, drain_addr_d;
    logic        pend_valid_q, pend_valid_d;
    logic [31:0] pend_pc_q, pend_pc_d;
    logic [31:0] pend_inst_q, pend_inst_d;
    logic        if_id_valid_q, if_id_valid_d;
    logic [31:0] if_id_pc_q, if_id_pc_d;
    logic [31:0] if_id_inst_q, if_id_inst_d;
    logic        fetch_done;
    logic        unused_br_lsb;

    assign unused_br_lsb = ^br_target[1:0];

    assign imem_req   = ((state_q == S_REQ) && !pend_valid_q) || (state_q == S_DRAIN);
    assign imem_addr  = (state_q == S_DRAIN) ? drain_addr_q : pc_q;
    assign fetch_done = (state_q == S_REQ) && imem_req && imem_ack;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        drain_addr_d  = drain_addr_q;
        pend_valid_d  = pend_valid_q;
        pend_pc_d     = pend_pc_q;
        pend_inst_d   = pend_inst_q;
        if_id_valid_d = if_id_valid_q;
        if_id_pc_d    = if_id_pc_q;
        if_id_inst_d  = if_id_inst_q;

        case (state_q)
            S_IDLE:  state_d = S_REQ;
            S_REQ:   if (fetch_done) pc_d = pc_q + 32'd4;
            S_DRAIN: if (imem_ack) state_d = S_REQ;
            default: state_d = S_IDLE;
        endcase

        if (!id_stall) begin
            if (pend_valid_q) begin
                if_id_valid_d = 1'b1;
                if_id_pc_d    = pend_pc_q;
                if_id_inst_d  = pend_inst_q;
                pend_valid_d  = 1'b0;
            end else if (fetch_done) begin
                if_id_valid_d = 1'b1;
                if_id_pc_d    = pc_q;
                if_id_inst_d  = imem_rdata;
            end else begin
                if_id_valid_d = 1'b0;
                if_id_inst_d  = NOP_INST;
            end
        end else if (fetch_done) begin
            pend_valid_d = 1'b1;
            pend_pc_d    = pc_q;
            pend_inst_d  = imem_rdata;
        end

        // A redirect with a request still waiting must first swallow its response.
        if (br_taken) begin
            pc_d          = {br_target[31:2], 2'b00};
            if_id_valid_d = 1'b0;
            if_id_inst_d  = NOP_INST;
            pend_valid_d  = 1'b0;
            if (state_q == S_DRAIN) begin
                state_d = S_DRAIN;
            end else if (imem_req && !imem_ack) begin
                state_d      = S_DRAIN;
                drain_addr_d = imem_addr;
            end else begin
                state_d = S_REQ;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            pc_q          <= RESET_PC;
            drain_addr_q  <= '0;
            pend_valid_q  <= 1'b0;
            pend_pc_q     <= '0;
            pend_inst_q   <= '0;
            if_id_valid_q <= 1'b0;
            if_id_pc_q    <= '0;
            if_id_inst_q  <= NOP_INST;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            drain_addr_q  <= drain_addr_d;
            pend_valid_q  <= pend_valid_d;
            pend_pc_q     <= pend_pc_d;
            pend_inst_q   <= pend_inst_d;
            if_id_valid_q <= if_id_valid_d;
            if_id_pc_q    <= if_id_pc_d;
            if_id_inst_q  <= if_id_inst_d;
        end
    end

    assign if_id_valid = if_id_valid_q;
    assign if_id_pc    = if_id_pc_q;
    assign if_id_inst  = if_id_inst_q;

endmodule
`default_nettype wire

// File: tb/tb_if_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_fetch
// Brief    : Directed and randomized bench for if_fetch with an in-order
//            instruction-stream reference model and handshake monitor.
// Revision : 1.0
// ============================================================================
module tb_if_fetch;

    localparam logic [31:0] C_RST_PC = 32'h0000_0100;
    localparam logic [31:0] C_NOP    = 32'h0000_0013;
    localparam logic [31:0] C_KEY    = 32'hA5A5_0000;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        br_taken;
    logic [31:0] br_target;
    logic        id_stall;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_inst;

    if_fetch #(.RESET_PC(C_RST_PC), .NOP_INST(C_NOP)) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .id_stall   (id_stall),
        .if_id_valid(if_id_valid),
        .if_id_pc   (if_id_pc),
        .if_id_inst (if_id_inst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          mem_lat = 0;
    int          waitc = 0;
    bit          rand_lat = 1'b0;
    int          consumed = 0;
    logic [31:0] exp_pc;
    bit          hold_req_chk, hold_ifid_chk, flush_chk;
    logic [31:0] hold_addr, hold_pc, hold_inst;
    logic        hold_valid;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_pc        = C_RST_PC;
        waitc         = 0;
        hold_req_chk  = 1'b0;
        hold_ifid_chk = 1'b0;
        flush_chk     = 1'b0;
    endtask

    // Called at a falling edge with id_stall/br_taken already set; the memory
    // answers, the stream model checks decode's view, then one cycle elapses.
    task automatic tick();
        if (imem_req && waitc >= mem_lat) begin
            imem_ack   = 1'b1;
            imem_rdata = imem_addr ^ C_KEY;
        end else begin
            imem_ack   = 1'b0;
            imem_rdata = $urandom;
        end
        if (hold_req_chk) begin
            chk1("req_stable", imem_req, 1'b1);
            chk32("addr_stable", imem_addr, hold_addr);
        end
        if (hold_ifid_chk) begin
            chk1("stall_hold_valid", if_id_valid, hold_valid);
            chk32("stall_hold_pc", if_id_pc, hold_pc);
            chk32("stall_hold_inst", if_id_inst, hold_inst);
        end
        if (flush_chk) begin
            chk1("flush_valid", if_id_valid, 1'b0);
            chk32("flush_inst", if_id_inst, C_NOP);
        end
        if (!if_id_valid) chk32("bubble_inst", if_id_inst, C_NOP);
        if (if_id_valid && !id_stall && !br_taken) begin
            chk32("stream_pc", if_id_pc, exp_pc);
            chk32("stream_inst", if_id_inst, exp_pc ^ C_KEY);
            exp_pc = exp_pc + 32'd4;
            consumed++;
        end
        if (br_taken) exp_pc = {br_target[31:2], 2'b00};
        hold_req_chk  = imem_req && !imem_ack;
        hold_addr     = imem_addr;
        hold_ifid_chk = id_stall && !br_taken;
        hold_valid    = if_id_valid;
        hold_pc       = if_id_pc;
        hold_inst     = if_id_inst;
        flush_chk     = br_taken;
        if (imem_req && !imem_ack) begin
            waitc++;
        end else begin
            waitc = 0;
            if (rand_lat) mem_lat = $urandom_range(0, 3);
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; imem_ack = 1'b0; imem_rdata = '0;
        br_taken = 1'b0; br_target = '0; id_stall = 1'b0;
        model_reset();
        @(negedge clk);
        chk1("rst_req", imem_req, 1'b0);
        chk32("rst_addr", imem_addr, C_RST_PC);
        chk1("rst_valid", if_id_valid, 1'b0);
        chk32("rst_pc", if_id_pc, 32'h0);
        chk32("rst_inst", if_id_inst, C_NOP);
        rst = 1'b0;

        // Zero-wait streaming from reset
        chk1("idle_req", imem_req, 1'b0);
        tick();
        chk1("first_req", imem_req, 1'b1);
        chk32("first_addr", imem_addr, 32'h100);
        tick();
        chk32("stream_addr1", imem_addr, 32'h104);
        chk1("stream_valid1", if_id_valid, 1'b1);
        chk32("stream_pc1", if_id_pc, 32'h100);
        chk32("stream_inst1", if_id_inst, 32'hA5A5_0100);
        tick();
        chk32("stream_addr2", imem_addr, 32'h108);
        chk32("stream_pc2", if_id_pc, 32'h104);

        // Three-cycle stall with the 0x108 response parked in the skid buffer
        id_stall = 1'b1;
        tick();
        chk1("skid_req_low", imem_req, 1'b0);
        chk32("skid_hold_pc", if_id_pc, 32'h104);
        tick();
        tick();
        id_stall = 1'b0;
        chk1("skid_req_low2", imem_req, 1'b0);
        chk32("skid_hold_pc2", if_id_pc, 32'h104);
        tick();
        chk32("skid_release_pc", if_id_pc, 32'h108);
        chk32("skid_resume_addr", imem_addr, 32'h10C);
        tick();
        chk32("skid_next_pc", if_id_pc, 32'h10C);

        // Three-cycle memory, redirect in the second wait cycle
        mem_lat = 3;
        tick();
        br_taken = 1'b1; br_target = 32'h2002;
        tick();
        br_taken = 1'b0;
        chk32("drain_addr_held", imem_addr, 32'h110);
        chk1("drain_flushed", if_id_valid, 1'b0);
        tick();
        tick();
        chk32("redir_addr", imem_addr, 32'h2000);
        chk1("redir_stale_dropped", if_id_valid, 1'b0);
        repeat (4) tick();
        chk1("lat3_valid", if_id_valid, 1'b1);
        chk32("lat3_pc", if_id_pc, 32'h2000);
        tick();
        chk1("lat3_gap", if_id_valid, 1'b0);
        repeat (3) tick();
        chk32("lat3_next_pc", if_id_pc, 32'h2004);

        // Redirect coinciding with a zero-wait ack, target near the top of memory
        mem_lat = 0;
        chk1("sameack_req", imem_req, 1'b1);
        br_taken = 1'b1; br_target = 32'hFFFF_FFFE;
        tick();
        br_taken = 1'b0;
        chk1("sameack_valid", if_id_valid, 1'b0);
        chk32("sameack_addr", imem_addr, 32'hFFFF_FFFC);
        tick();
        chk32("wrap_pc", if_id_pc, 32'hFFFF_FFFC);
        chk32("wrap_addr", imem_addr, 32'h0);

        // Flush beats stall
        chk1("fbs_pre_valid", if_id_valid, 1'b1);
        id_stall = 1'b1; br_taken = 1'b1; br_target = 32'h4000;
        tick();
        id_stall = 1'b0; br_taken = 1'b0;
        chk1("fbs_valid", if_id_valid, 1'b0);
        chk32("fbs_inst", if_id_inst, C_NOP);
        chk32("fbs_addr", imem_addr, 32'h4000);
        tick();
        chk32("fbs_next_pc", if_id_pc, 32'h4000);

        // Asynchronous reset while draining
        mem_lat = 3;
        tick();
        br_taken = 1'b1; br_target = 32'h5000;
        tick();
        br_taken = 1'b0;
        chk32("pre_rst_drain_addr", imem_addr, 32'h4004);
        #2 rst = 1'b1;
        #1;
        chk1("arst_req", imem_req, 1'b0);
        chk32("arst_addr", imem_addr, C_RST_PC);
        chk1("arst_valid", if_id_valid, 1'b0);
        chk32("arst_pc", if_id_pc, 32'h0);
        chk32("arst_inst", if_id_inst, C_NOP);
        imem_ack = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        mem_lat = 0;
        chk1("arst_idle_req", imem_req, 1'b0);
        tick();
        chk1("arst_restart_req", imem_req, 1'b1);
        chk32("arst_restart_addr", imem_addr, C_RST_PC);
        tick();
        chk32("arst_restart_pc", if_id_pc, C_RST_PC);

        // Randomized latency, stalls and redirects against the stream model
        rand_lat = 1'b1;
        consumed = 0;
        for (int i = 0; i < 3000; i++) begin
            id_stall  = ($urandom_range(0, 99) < 30);
            br_taken  = ($urandom_range(0, 99) < 4);
            br_target = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF8 : $urandom;
            tick();
        end
        id_stall = 1'b0; br_taken = 1'b0;
        chk1("random_progress", consumed >= 300, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
